// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
//   Constants and helpers shared by the BCD adder datapath.
//   ADDER_W : digit width used by the BCD datapath (one binary adder digit)
//   BCD_FIX : decimal-correction addend applied when a digit sum exceeds 9
//   maj()   : three-input majority, the carry function of a full adder
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int unsigned ADDER_W = 4;
    localparam logic [3:0]  BCD_FIX = 4'b0110;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage : arith_pkg

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//   One-bit combinational full adder, the cell of the ripple chain.
//   a, b : addend bits
//   ci   : carry in from the next-lower bit
//   s    : sum bit, a ^ b ^ ci
//   co   : carry out to the next-higher bit, majority(a, b, ci)
// ---------------------------------------------------------------------------
module full_adder
    import arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = maj(a, b, ci);

endmodule : full_adder

// File: rtl/adder_4_bit.sv
// ---------------------------------------------------------------------------
// adder_4_bit
//   Registered ripple-carry adder with carry-in, carry-out and signed
//   overflow flag. Operands presented with in_valid=1 at a rising edge
//   appear on the outputs after that edge, with out_valid=1 for one cycle.
//   When in_valid=0 the result registers hold and out_valid drops.
//
//   Ports
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset (clears all outputs)
//     a, b      WIDTH-bit unsigned operands
//     cin       carry-in
//     in_valid  operands valid this cycle
//     s         registered sum, (a + b + cin) mod 2^WIDTH
//     cout      registered carry-out, bit WIDTH of a + b + cin
//     ovf       registered two's-complement overflow
//     out_valid s/cout/ovf hold a result sampled on the previous edge
// ---------------------------------------------------------------------------
module adder_4_bit
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    // Carry chain: c[0] is the carry-in, c[i+1] is the carry out of bit i.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_next;
    logic             ovf_next;

    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             valid_reg;

    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_ripple
            full_adder u_fa (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (c[gi]),
                .s  (sum_next[gi]),
                .co (c[gi+1])
            );
        end
    endgenerate

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign ovf_next = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            // Result registers only load on valid operands so a downstream
            // consumer can still read the last result while idle.
            if (in_valid) begin
                sum_reg  <= sum_next;
                cout_reg <= c[WIDTH];
                ovf_reg  <= ovf_next;
            end
        end
    end

    assign s         = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign out_valid = valid_reg;

endmodule : adder_4_bit

// File: tb/tb_adder_4_bit.sv
// ---------------------------------------------------------------------------
// tb_adder_4_bit
//   Directed bench for adder_4_bit at WIDTH=4. Each check compares the packed
//   output word {out_valid, ovf, cout, s} against a hand-computed value, plus
//   an exhaustive back-to-back sweep of all operand/carry combinations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adder_4_bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       out_valid;

    int checks;
    int errors;

    adder_4_bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare {out_valid, ovf, cout, s} with the expected word.
    task automatic check(input string tag, input logic [6:0] expected);
        logic [6:0] observed;
        observed = {out_valid, ovf, cout, s};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed v/ovf/cout/s=%b expected %b", tag, observed, expected);
        end
        $display("check %-12s a=%b b=%b cin=%b -> v=%b ovf=%b cout=%b s=%b", tag,
                 a, b, cin, out_valid, ovf, cout, s);
    endtask

    // Present one operand set, clock it in, and sample 1 ns after the edge.
    task automatic op(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                      input logic vv);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = vv;
        @(posedge clk);
        #1;
    endtask

    // Safety net: the run is a fixed number of clocks, so this never fires
    // unless the simulator stops advancing the bench.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] full;
        logic       exp_ovf;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        in_valid = 1'b0;

        // Reset state at power-up.
        #2;
        check("por", 7'b0_0_0_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic adds, back to back.       {v, ovf, cout, s}
        op(4'b0110, 4'b1001, 1'b0, 1'b1); check("add_6_9",   7'b1_0_0_1111);
        op(4'b0011, 4'b0011, 1'b1, 1'b1); check("add_3_3_c", 7'b1_0_0_0111);
        op(4'b0100, 4'b0101, 1'b0, 1'b1); check("add_4_5",   7'b1_1_0_1001);

        // BCD-range carries.
        op(4'b1001, 4'b1001, 1'b1, 1'b1); check("bcd_9_9_c", 7'b1_1_1_0011);
        op(4'b1000, 4'b0010, 1'b0, 1'b1); check("bcd_8_2",   7'b1_0_0_1010);
        op(4'b0110, 4'b1010, 1'b0, 1'b1); check("bcd_fix",   7'b1_0_1_0000);

        // Boundaries.
        op(4'b1111, 4'b0000, 1'b1, 1'b1); check("wrap",      7'b1_0_1_0000);
        op(4'b1111, 4'b1111, 1'b1, 1'b1); check("all_ones",  7'b1_0_1_1111);
        op(4'b0111, 4'b0001, 1'b0, 1'b1); check("ovf_pos",   7'b1_1_0_1000);

        // Valid gating: result holds, out_valid drops, then resumes.
        op(4'b0011, 4'b0100, 1'b0, 1'b1); check("gate_load", 7'b1_0_0_0111);
        op(4'b1111, 4'b1111, 1'b1, 1'b0); check("gate_hold", 7'b0_0_0_0111);
        op(4'b1010, 4'b1010, 1'b0, 1'b0); check("gate_hold2",7'b0_0_0_0111);
        op(4'b0001, 4'b0010, 1'b0, 1'b1); check("gate_resume",7'b1_0_0_0011);

        // Asynchronous reset mid-cycle with valid operands present.
        op(4'b1001, 4'b1001, 1'b0, 1'b1); check("pre_reset", 7'b1_1_1_0010);
        a        = 4'b0110;
        b        = 4'b1001;
        cin      = 1'b0;
        in_valid = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async",  7'b0_0_0_0000);
        @(posedge clk);
        #1;
        check("rst_held",   7'b0_0_0_0000);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release",7'b0_0_0_0000);
        op(4'b0110, 4'b1001, 1'b0, 1'b1); check("post_reset", 7'b1_0_0_1111);

        // Exhaustive sweep with back-to-back valid operands.
        for (int i = 0; i < 512; i++) begin
            op(i[3:0], i[7:4], i[8], 1'b1);
            full    = {1'b0, i[3:0]} + {1'b0, i[7:4]} + {4'b0000, i[8]};
            // Signed overflow: equal operand signs, result sign differs.
            exp_ovf = (i[3] == i[7]) && (full[3] != i[3]);
            check("sweep", {1'b1, exp_ovf, full});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_adder_4_bit

// File: doc/adder_4_bit.md
# adder_4_bit

Registered 4-bit binary ripple-carry adder with carry-in and carry-out. It is the arithmetic primitive of the BCD adder datapath, used both for the raw binary sum of two digits and for the +6 (0110) decimal-correction add. Inputs are sampled on the rising clock edge and results are presented from registers one cycle later, with a valid qualifier.

## Interface
Parameters:
- WIDTH, default 4: operand width. The BCD datapath uses only 4; the parameter lets tests sweep other widths.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in
- in_valid  input  1  operands are valid this cycle
- s  output  WIDTH  registered sum, a+b+cin mod 2^WIDTH
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin
- ovf  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB
- out_valid  output  1  s/cout/ovf hold a fresh result

## Operation
- Full sum {cout, s} = a + b + cin, computed as a WIDTH+1-bit unsigned quantity. Range is 0..2^(WIDTH+1)-1; for WIDTH=4 this is 0..31.
- Carry chain is an explicit ripple of WIDTH full-adder cells. c[0]=cin and c[i+1]=maj(a[i],b[i],c[i]). s[i]=a[i]^b[i]^c[i]. cout=c[WIDTH]. ovf=c[WIDTH]^c[WIDTH-1].
- Operands are unsigned. ovf is informational only, for signed users.
- in_valid=1 at a rising edge: s, cout and ovf load the new result and out_valid goes to 1.
- in_valid=0 at a rising edge: s, cout and ovf hold their previous values and out_valid goes to 0.
- No backpressure. The block accepts an operand set every cycle.
- All-ones boundary: a=b=1111, cin=1 gives s=1111, cout=1.
- Wrap-around: a=1111, b=0000, cin=1 gives s=0000, cout=1.

## Timing
- Latency is exactly 1 cycle: operands sampled at edge N appear on the outputs after edge N, and out_valid is asserted for that same cycle.
- Throughput is 1 result per cycle.
- Reset asserted (rst_n=0), asynchronously and regardless of clk: s=0, cout=0, ovf=0, out_valid=0.
- Reset deasserts synchronously to clk, with registers released on the first rising edge after rst_n=1.
- Reset mid-stream: any in-flight result is discarded. The first valid output after reset comes 1 cycle after the first in_valid sampled with rst_n=1.
- Combinational path: from input registers' launch through the ripple chain, WIDTH full-adder delays. No multicycle paths.

## Structure
- Shared package (arith_pkg) holds the ADDER_W=4 constant and the BCD correction constant BCD_FIX=4'b0110, so the BCD wrapper and this block share one value.
- One sub-module: full_adder (a, b, ci -> s, co), purely combinational, instantiated WIDTH times through a generate loop.
- Top level contains the generate chain, the overflow XOR and the output/valid registers. No FSM.

## Test plan
- Reset: drive rst_n=0 mid-cycle with in_valid=1, a=0110, b=1001 -> s=0000, cout=0, ovf=0, out_valid=0 immediately, and they stay so until after release.
- Basic adds, one per cycle with in_valid=1:
  - 0110+1001+0 -> s=1111, cout=0, ovf=0
  - 0011+0011+1 -> s=0111, cout=0
  - 0100+0101+0 -> s=1001, cout=0
- BCD-range carries:
  - 1001+1001+1 -> s=0011, cout=1
  - 1000+0010+0 -> s=1010, cout=0
  - correction add 0110+1010+0 -> s=0000, cout=1
- Boundaries:
  - 1111+0000+1 -> s=0000, cout=1
  - 1111+1111+1 -> s=1111, cout=1
  - 0111+0001+0 -> s=1000, ovf=1
- Valid gating: apply a result, then drop in_valid with different operands -> outputs hold the prior s/cout and out_valid=0. Re-raise in_valid -> new result after 1 cycle.
- Exhaustive sweep: all 512 (a, b, cin) combinations at WIDTH=4 with back-to-back in_valid -> each {cout, s} equals a+b+cin exactly 1 cycle later.
